// File: rtl/debounce_sync.sv
// debounce_sync: input-conditioning stage for a bouncy asynchronous input.
//
// The raw input is brought into the clock domain through a flop chain. The
// synchronized value must then differ from the current debounced level for
// STABLE_CYCLES consecutive cycles before it is accepted. An accepted change
// toggles level_out and fires a one-cycle rise or fall pulse. Accepted rising
// edges are also counted, and the count wraps silently.
//
// Ports:
//   clock       rising-edge clock (single domain)
//   reset       asynchronous, active-high reset
//   noisy_in    raw asynchronous input, may bounce or glitch
//   level_out   debounced, registered level
//   rise_pulse  one-cycle pulse on an accepted 0->1 change
//   fall_pulse  one-cycle pulse on an accepted 1->0 change
//   busy        high while a candidate change is being timed
//   event_count accepted rising edges, modulo 2^COUNT_WIDTH
//
// Parameters:
//   SYNC_STAGES   synchronizer depth, 2..4
//   STABLE_CYCLES stable cycles required to accept a change, 1..65535
//   COUNT_WIDTH   width of the rising-edge event counter

module debounce_sync #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned COUNT_WIDTH   = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   noisy_in,
  output logic                   level_out,
  output logic                   rise_pulse,
  output logic                   fall_pulse,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] event_count
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [COUNT_WIDTH-1:0] EVT_ONE = COUNT_WIDTH'(1);

  typedef enum logic {
    IDLE     = 1'b0,
    CHECKING = 1'b1
  } state_t;

  state_t               state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 synced;
  logic [CNT_W-1:0]     stable_cnt_q;
  logic [CNT_W-1:0]     stable_cnt_nxt;
  logic                 differs;
  logic                 accept;

  // Synchronizer chain; only stage 0 ever samples noisy_in.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], noisy_in};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // The counter sits at 0 in IDLE, so stable_cnt_nxt is 1 there. A single
  // compare therefore covers both acceptance in IDLE (STABLE_CYCLES == 1)
  // and acceptance at the end of the CHECKING interval.
  always_comb begin
    stable_cnt_nxt = stable_cnt_q + CNT_ONE;
    differs        = (synced != level_out);
    accept         = differs && (stable_cnt_nxt == CNT_MAX);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      stable_cnt_q <= '0;
      level_out    <= 1'b0;
      rise_pulse   <= 1'b0;
      fall_pulse   <= 1'b0;
      busy         <= 1'b0;
      event_count  <= '0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      case (state_q)
        IDLE: begin
          if (differs && accept) begin
            level_out    <= ~level_out;
            rise_pulse   <= ~level_out;
            fall_pulse   <= level_out;
            if (!level_out) begin
              event_count <= event_count + EVT_ONE;
            end
            stable_cnt_q <= '0;
            busy         <= 1'b0;
          end else if (differs) begin
            stable_cnt_q <= CNT_ONE;
            state_q      <= CHECKING;
            busy         <= 1'b1;
          end else begin
            stable_cnt_q <= '0;
            busy         <= 1'b0;
          end
        end
        CHECKING: begin
          if (!differs) begin
            // Bounced back to the old level: drop the candidate.
            stable_cnt_q <= '0;
            state_q      <= IDLE;
            busy         <= 1'b0;
          end else if (accept) begin
            level_out    <= ~level_out;
            rise_pulse   <= ~level_out;
            fall_pulse   <= level_out;
            if (!level_out) begin
              event_count <= event_count + EVT_ONE;
            end
            stable_cnt_q <= '0;
            state_q      <= IDLE;
            busy         <= 1'b0;
          end else begin
            stable_cnt_q <= stable_cnt_nxt;
            busy         <= 1'b1;
          end
        end
        default: begin
          stable_cnt_q <= '0;
          state_q      <= IDLE;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule
